// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between N_REQ byte requesters.
// One frame is FRAME_TICKS baud rising edges, followed by GAP_TICKS idle edges.
`timescale 1ns/1ps
module uart_tx_sched #(
   parameter int N_REQ       = 4,
   parameter int FRAME_TICKS = 10,
   parameter int GAP_TICKS   = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               baud_tick,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   ack,
   output logic [N_REQ-1:0]   grant,
   output logic               tx_en,
   output logic [7:0]         tx_data,
   output logic               busy
);

   localparam int CNT_MAX = (FRAME_TICKS > GAP_TICKS) ? FRAME_TICKS : GAP_TICKS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PTR_W   = $clog2(N_REQ);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
   localparam logic [PTR_W-1:0] PTR_INIT   = PTR_W'(N_REQ - 1);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t             state, state_nxt;
   logic               baud_q, rise;
   logic [CNT_W-1:0]   tick_cnt, tick_nxt;
   logic [PTR_W-1:0]   rr_ptr, rr_nxt, winner, scan_idx;
   logic               found;
   logic [N_REQ-1:0]   win_oh;
   logic [7:0]         req_bytes [N_REQ];
   logic [N_REQ-1:0]   ack_nxt, grant_nxt;
   logic               tx_en_nxt, busy_nxt;
   logic [7:0]         tx_data_nxt;

   for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
      assign req_bytes[g] = req_data[8*g +: 8];
   end

   // Frame timing only ever advances on a rising baud edge.
   assign rise = baud_tick & ~baud_q;

   // Scan starts just after the last winner, so the last winner has lowest priority.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = '0;
      win_oh   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         scan_idx = PTR_W'((int'(rr_ptr) + i) % N_REQ);
         if (!found && req[scan_idx]) begin
            found          = 1'b1;
            winner         = scan_idx;
            win_oh         = '0;
            win_oh[scan_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = SEND;
         SEND:    if (rise && tick_cnt == FRAME_LAST)
                     state_nxt = (GAP_TICKS == 0) ? IDLE : GAP;
         GAP:     if (rise && tick_cnt == GAP_LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ack_nxt     = '0;
      grant_nxt   = grant;
      tx_en_nxt   = tx_en;
      tx_data_nxt = tx_data;
      busy_nxt    = busy;
      tick_nxt    = tick_cnt;
      rr_nxt      = rr_ptr;
      case (state)
         IDLE: begin
            if (found) begin
               ack_nxt     = win_oh;
               grant_nxt   = win_oh;
               tx_en_nxt   = 1'b1;
               tx_data_nxt = req_bytes[winner];
               busy_nxt    = 1'b1;
               rr_nxt      = winner;
               tick_nxt    = '0;
            end
         end
         SEND: begin
            if (rise) begin
               if (tick_cnt == FRAME_LAST) begin
                  tx_en_nxt = 1'b0;
                  grant_nxt = '0;
                  tick_nxt  = '0;
                  busy_nxt  = (GAP_TICKS != 0);
               end else begin
                  tick_nxt = tick_cnt + 1'b1;
               end
            end
         end
         GAP: begin
            if (rise) begin
               if (tick_cnt == GAP_LAST) begin
                  busy_nxt = 1'b0;
                  tick_nxt = '0;
               end else begin
                  tick_nxt = tick_cnt + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Everything, byte latch included, clears on reset so an interrupted frame leaves no trace.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_q   <= 1'b0;
         tick_cnt <= '0;
         rr_ptr   <= PTR_INIT;
         ack      <= '0;
         grant    <= '0;
         tx_en    <= 1'b0;
         tx_data  <= '0;
         busy     <= 1'b0;
      end else begin
         baud_q   <= baud_tick;
         tick_cnt <= tick_nxt;
         rr_ptr   <= rr_nxt;
         ack      <= ack_nxt;
         grant    <= grant_nxt;
         tx_en    <= tx_en_nxt;
         tx_data  <= tx_data_nxt;
         busy     <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: default build plus a GAP_TICKS=0 build.
`timescale 1ns/1ps
module tb_uart_tx_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        baud_tick = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  ack, grant;
   logic        tx_en, busy;
   logic [7:0]  tx_data;

   logic [3:0]  req0 = '0;
   logic [31:0] req_data0 = '0;
   logic [3:0]  ack0, grant0;
   logic        tx_en0, busy0;
   logic [7:0]  tx_data0;

   uart_tx_sched u_dut (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(req), .req_data(req_data),
      .ack(ack), .grant(grant), .tx_en(tx_en), .tx_data(tx_data), .busy(busy)
   );

   uart_tx_sched #(.N_REQ(4), .FRAME_TICKS(10), .GAP_TICKS(0)) u_dut0 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(req0), .req_data(req_data0),
      .ack(ack0), .grant(grant0), .tx_en(tx_en0), .tx_data(tx_data0), .busy(busy0)
   );

   always #25   clk = ~clk;
   always #3250 baud_tick = ~baud_tick;

   int         total = 0;
   int         bad = 0;
   int         frame_rises = 0;
   int         gap_rises = 0;
   int         ack_cnt = 0;
   logic [3:0] ack_acc = '0;
   logic [7:0] frame_data = '0;
   logic       data_moved = 1'b0;
   logic       cur_baud = 1'b0;
   logic       prev_baud = 1'b0;
   logic       rise_s = 1'b0;
   logic       pre_tx_en = 1'b0;
   logic       pre_busy = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; observe 1 ns after the edge and account baud rises the DUT just saw.
   task automatic step();
      pre_tx_en = tx_en;
      pre_busy  = busy;
      @(posedge clk);
      #1;
      prev_baud = cur_baud;
      cur_baud  = baud_tick;
      rise_s    = cur_baud & ~prev_baud;
      if (rise_s && pre_tx_en) frame_rises++;
      if (rise_s && pre_busy && !pre_tx_en) gap_rises++;
      if (ack !== 4'b0000) ack_cnt++;
      ack_acc = ack_acc | ack;
      if (pre_tx_en && tx_en && (tx_data !== frame_data)) data_moved = 1'b1;
   endtask

   task automatic start_frame(input string tag, input int idx, input logic [7:0] d);
      int n = 0;
      while (tx_en !== 1'b1 && n < 400) begin
         step();
         n++;
      end
      chk({tag, "_tx_en"}, 32'(tx_en), 32'd1);
      chk({tag, "_ack"}, 32'(ack), 32'(4'b0001 << idx));
      chk({tag, "_grant"}, 32'(grant), 32'(4'b0001 << idx));
      chk({tag, "_data"}, 32'(tx_data), 32'(d));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      frame_rises = 0;
      gap_rises   = 0;
      ack_cnt     = (ack !== 4'b0000) ? 1 : 0;
      ack_acc     = ack;
      frame_data  = d;
      data_moved  = 1'b0;
   endtask

   task automatic end_frame(input string tag, input int idx, input int gap_exp);
      int n = 0;
      while (tx_en === 1'b1 && n < 2000) begin
         step();
         n++;
      end
      chk({tag, "_rises"}, 32'(frame_rises), 32'd10);
      chk({tag, "_grant_off"}, 32'(grant), 32'd0);
      chk({tag, "_held"}, 32'(data_moved), 32'd0);
      chk({tag, "_ack_cnt"}, 32'(ack_cnt), 32'd1);
      chk({tag, "_ack_who"}, 32'(ack_acc), 32'(4'b0001 << idx));
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         step();
         n++;
      end
      chk({tag, "_gap"}, 32'(gap_rises), 32'(gap_exp));
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      int low;
      step();
      step();
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_tx_en", 32'(tx_en), 32'd0);
      chk("rst_data", 32'(tx_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      step();
      step();

      // single requester
      req_data = 32'h0000_B400;
      req      = 4'b0010;
      start_frame("t1", 1, 8'hB4);
      req = 4'b0000;
      end_frame("t1", 1, 1);

      // all four held; pointer sits at 1, so service runs 2,3,0,1
      req_data = 32'h4433_2211;
      req      = 4'b1111;
      start_frame("t2a", 2, 8'h33);
      end_frame("t2a", 2, 1);
      start_frame("t2b", 3, 8'h44);
      end_frame("t2b", 3, 1);
      start_frame("t2c", 0, 8'h11);
      end_frame("t2c", 0, 1);
      start_frame("t2d", 1, 8'h22);
      end_frame("t2d", 1, 1);

      req = 4'b1001;
      start_frame("t3a", 3, 8'h44);
      req = 4'b0001;
      end_frame("t3a", 3, 1);
      start_frame("t3b", 0, 8'h11);
      req = 4'b0000;
      end_frame("t3b", 0, 1);

      // withdrawn request and mid-frame data change
      req_data[7:0] = 8'hA5;
      req           = 4'b0001;
      start_frame("t4", 0, 8'hA5);
      req = 4'b0000;
      repeat (20) step();
      req[2] = 1'b1;
      repeat (5) step();
      req[2]        = 1'b0;
      req_data[7:0] = 8'h5A;
      repeat (20) step();
      chk("t4_mid_data", 32'(tx_data), 32'h0000_00A5);
      end_frame("t4", 0, 1);
      repeat (10) step();
      chk("t4_quiet_tx_en", 32'(tx_en), 32'd0);
      chk("t4_quiet_ack", 32'(ack_acc), 32'h1);

      // reset five rises into a frame
      req_data = 32'h44C3_225A;
      req      = 4'b0100;
      start_frame("t5a", 2, 8'hC3);
      req = 4'b0000;
      n = 0;
      while (frame_rises < 5 && n < 1000) begin
         step();
         n++;
      end
      chk("t5_in_frame", 32'(tx_en), 32'd1);
      #5 rst = 1'b1;
      #1;
      chk("t5_rst_ack", 32'(ack), 32'd0);
      chk("t5_rst_grant", 32'(grant), 32'd0);
      chk("t5_rst_tx_en", 32'(tx_en), 32'd0);
      chk("t5_rst_data", 32'(tx_data), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      step();
      step();
      rst = 1'b0;
      step();
      step();
      chk("t5_no_replay", 32'(ack), 32'd0);
      req = 4'b1000;
      start_frame("t5b", 3, 8'h44);
      req = 4'b0000;
      end_frame("t5b", 3, 1);

      // no-gap build: back-to-back frames with a single idle clock
      req_data0 = 32'h0000_6677;
      req0      = 4'b0011;
      n = 0;
      while (tx_en0 !== 1'b1 && n < 400) begin
         step();
         n++;
      end
      chk("t6_first_ack", 32'(ack0), 32'h1);
      chk("t6_first_grant", 32'(grant0), 32'h1);
      chk("t6_first_data", 32'(tx_data0), 32'h77);
      req0 = 4'b0010;
      n = 0;
      while (tx_en0 === 1'b1 && n < 2000) begin
         step();
         n++;
      end
      chk("t6_gap_busy", 32'(busy0), 32'd0);
      low = 1;
      while (tx_en0 !== 1'b1 && low < 400) begin
         step();
         if (tx_en0 !== 1'b1) low++;
      end
      chk("t6_low_clks", 32'(low), 32'd1);
      chk("t6_second_ack", 32'(ack0), 32'h2);
      chk("t6_second_grant", 32'(grant0), 32'h2);
      chk("t6_second_data", 32'(tx_data0), 32'h66);
      req0 = 4'b0000;
      n = 0;
      while (tx_en0 === 1'b1 && n < 2000) begin
         step();
         n++;
      end
      chk("t6_end_tx_en", 32'(tx_en0), 32'd0);
      chk("t6_end_busy", 32'(busy0), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
